// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES key-schedule types, constants and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Word counter / index width; covers 0..43.
    localparam int c_IDX_W = 6;
    // Total expanded words for AES-128: 4 x (10 + 1).
    localparam int c_NUM_WORDS = 44;
    // First round constant and the GF(2^8) reduction term used by xtime.
    localparam logic [7:0] c_RCON_INIT  = 8'h01;
    localparam logic [7:0] c_XTIME_POLY = 8'h1B;

    // Key-generator FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? c_XTIME_POLY : 8'h00);
    endfunction

    // Cyclic one-byte left rotation: {b3,b2,b1,b0} -> {b2,b1,b0,b3}.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational FIPS-197 forward S-box, 8-bit in / 8-bit out.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] Din,
    output logic [7:0] Dout
);

    // Table packed with entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n sits at bit offset 8*(255-n); 255-n is simply ~n.
    logic [10:0] w_pos;
    assign w_pos = {~Din, 3'b000};
    assign Dout  = c_SBOX[w_pos +: 8];

endmodule
`default_nettype wire

// File: rtl/key_word_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_word_gen
// Description : Iterative AES-128 key schedule; streams w0..w43 one word per
//               clock with index and valid strobe for the round-key bank.
// Revision    : 1.0 - initial release
// ============================================================================
module key_word_gen
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 44
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [127:0]          Key_in,
    output logic [DATA_WIDTH-1:0] Word_out,
    output logic [c_IDX_W-1:0]    Word_idx,
    output logic                  Word_valid,
    output logic                  Busy,
    output logic                  Done
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_win [4];   // w[i-4] .. w[i-1], oldest first
    logic [c_IDX_W-1:0]    r_cnt;       // index of the word produced next
    logic [7:0]            r_rcon;

    logic [DATA_WIDTH-1:0] w_rot;
    logic [DATA_WIDTH-1:0] w_sub;
    logic [DATA_WIDTH-1:0] w_temp;
    logic [DATA_WIDTH-1:0] w_next;
    logic                  w_rcon_step;

    assign w_rot = rot_word(r_win[3]);

    // SubWord: four parallel byte substitutions of the rotated newest word.
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .Din  (w_rot[8*g +: 8]),
            .Dout (w_sub[8*g +: 8])
        );
    end

    // Next schedule word; every fourth index mixes in SubWord/RotWord/Rcon.
    always_comb begin
        w_rcon_step = (r_cnt[1:0] == 2'b00);
        w_temp      = w_rcon_step ? (w_sub ^ {r_rcon, 24'h000000}) : r_win[3];
        w_next      = r_win[0] ^ w_temp;
    end

    // Sequencer: load, emit key words, expand, pulse Done, return to idle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= ST_IDLE;
            for (int k = 0; k < 4; k++) r_win[k] <= '0;
            r_cnt      <= '0;
            r_rcon     <= '0;
            Word_out   <= '0;
            Word_idx   <= '0;
            Word_valid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    Word_valid <= 1'b0;
                    if (Start) begin
                        r_win[0] <= Key_in[127:96];
                        r_win[1] <= Key_in[95:64];
                        r_win[2] <= Key_in[63:32];
                        r_win[3] <= Key_in[31:0];
                        r_cnt    <= '0;
                        r_rcon   <= c_RCON_INIT;
                        Busy     <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Window stays put; the key words are read out in place.
                    Word_out   <= r_win[r_cnt[1:0]];
                    Word_idx   <= r_cnt;
                    Word_valid <= 1'b1;
                    r_cnt      <= r_cnt + c_IDX_W'(1);
                    if (r_cnt[1:0] == 2'd3) r_state <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    Word_out   <= w_next;
                    Word_idx   <= r_cnt;
                    Word_valid <= 1'b1;
                    r_win[0]   <= r_win[1];
                    r_win[1]   <= r_win[2];
                    r_win[2]   <= r_win[3];
                    r_win[3]   <= w_next;
                    r_cnt      <= r_cnt + c_IDX_W'(1);
                    if (w_rcon_step) r_rcon <= xtime(r_rcon);
                    if (r_cnt == c_IDX_W'(NUM_WORDS - 1)) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    Word_valid <= 1'b0;
                    Busy       <= 1'b0;
                    Done       <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
